lut_arbiter: RTL and testbench
==============================

LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter AW, default 8, LUT address width; must equal the width of the mainLUT address port.
REQ-002 Parameter DW, default 8, LUT data width; must equal the width of the mainLUT qspo port.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  4  per-requester lookup request; bit i belongs to requester i.
REQ-006 addr  input  4*AW  packed lookup addresses; requester i uses bits [i*AW +: AW].
REQ-007 gnt  output  4  one-hot grant; gnt[i]=1 means requester i's address is accepted this cycle.
REQ-008 lut_a  output  AW  address to the shared LUT.
REQ-009 lut_qspo  input  DW  registered LUT output; valid one clk after lut_a is presented.
REQ-010 rd_valid  output  4  one-hot result strobe; bit i flags data for requester i.
REQ-011 rd_data  output  DW  lookup result shared by all requesters; qualified by rd_valid.
REQ-012 busy  output  1  high in any cycle where gnt is non-zero.

Function
REQ-013 The block shall share one single-port, 1-cycle-latency LUT among 4 requesters, granting at most one requester per cycle.
REQ-014 gnt shall be combinational from req and the priority pointer ptr[1:0]: the first asserted req bit, scanning ptr, ptr+1, ... mod 4, wins.
REQ-015 gnt shall be all-zero when req==0 or when rst=1.
REQ-016 A request is accepted on the rising edge that ends a cycle in which gnt[i]=1; a requester whose grant is 0 shall hold req and addr unchanged until granted.
REQ-017 In a grant cycle, lut_a shall equal the granted requester's address combinationally; in a non-grant cycle, lut_a shall hold the last granted address, held in register lut_a_q.
REQ-018 rd_valid shall be a registered copy of gnt: a grant in cycle N gives rd_valid[i]=1 in cycle N+1 only, so latency is exactly 1 cycle.
REQ-019 rd_data shall pass lut_qspo straight through with no extra register; it is meaningful only when rd_valid is non-zero.
REQ-020 On a grant to requester i, ptr shall update to (i+1) mod 4, wrapping 3 to 0; with no grant, ptr shall hold.
REQ-021 Back-to-back grants shall be supported: with several req bits held, one grant per cycle and sustained throughput of 1 lookup per cycle.
REQ-022 A requester that keeps req high after acceptance is treated as a new request; it competes under the updated ptr.
REQ-023 With all 4 requesters continuously asserting, the grant sequence shall be ptr, ptr+1, ... with no requester starved for more than 3 consecutive grants.

Reset
REQ-024 While rst=1 at a clock edge, the block shall clear ptr to 0, rd_valid to 0 and lut_a_q to 0.
REQ-025 Outputs during rst=1 shall be: gnt=0, busy=0, lut_a=0.
REQ-026 A grant issued in the cycle in which rst rises shall be discarded: gnt is forced 0 and rd_valid stays 0 in the following cycle.
REQ-027 The first grant after rst deasserts shall follow ptr=0 priority.

Configuration
REQ-028 Macro LUT_ARB_FIXED_PRIO_EN controls the arbitration policy.
REQ-029 When LUT_ARB_FIXED_PRIO_EN is defined: ptr is not implemented; priority is fixed, req[0] highest to req[3] lowest; REQ-020, REQ-023 and REQ-027 do not apply, and starvation of lower requesters is permitted.
REQ-030 When LUT_ARB_FIXED_PRIO_EN is undefined: round-robin per REQ-014, REQ-020 and REQ-023; all other behaviour is identical in both builds.

Verification (bench models the LUT as a 1-cycle registered ROM with qspo = a XOR 8'hA5)
REQ-031 Reset, then req=4'b0010 with addr1=8'h33 for one cycle -> gnt=4'b0010 and lut_a=8'h33 that cycle; next cycle rd_valid=4'b0010 and rd_data=8'h96.
REQ-032 req=4'b1111 held for 8 cycles after reset (round-robin build) -> gnt sequence 0001,0010,0100,1000,0001,...; rd_valid trails gnt by one cycle; busy=1 throughout.
REQ-033 Same stimulus with LUT_ARB_FIXED_PRIO_EN defined -> gnt=4'b0001 every cycle.
REQ-034 req=4'b1001 with ptr=3 (previous grant to requester 2) -> requester 3 granted first, then requester 0; ptr wraps 3 to 0.
REQ-035 rst asserted in a cycle where gnt=4'b0100 -> gnt=0 that cycle, rd_valid=0 in the next cycle, ptr=0 after reset.
REQ-036 req=0 for 3 cycles after a grant with addr=8'h10 -> gnt=0, busy=0, rd_valid=0, and lut_a holds 8'h10.

Source files
------------

// File: rtl/lut_arbiter.sv
// Shares one registered single-port LUT among four requesters with a one-hot grant.
// Round-robin arbitration by default; define LUT_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module lut_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*AW-1:0] addr,
    output logic [3:0]      gnt,
    output logic [AW-1:0]   lut_a,
    input  logic [DW-1:0]   lut_qspo,
    output logic [3:0]      rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            busy
);

    logic [1:0]    base;
    logic [1:0]    gnt_idx;
    logic [1:0]    idx;
    logic          found;
    logic [AW-1:0] lut_a_q;

`ifdef LUT_ARB_FIXED_PRIO_EN
    assign base = 2'd0;
`else
    logic [1:0] ptr;

    assign base = ptr;

    // The pointer moves just past the winner so it becomes lowest priority next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (found) begin
            ptr <= gnt_idx + 2'd1;
        end
    end
`endif

    // Scan base, base+1, ... mod 4 and take the first asserted request.
    always_comb begin
        found   = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (found && !rst) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign busy    = |gnt;
    assign rd_data = lut_qspo;

    // The LUT address is steered live on a grant and otherwise parks on the last granted address.
    always_comb begin
        if (rst) begin
            lut_a = '0;
        end else if (|gnt) begin
            lut_a = addr[int'(gnt_idx)*AW +: AW];
        end else begin
            lut_a = lut_a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_a_q  <= '0;
            rd_valid <= 4'b0000;
        end else begin
            rd_valid <= gnt;
            if (|gnt) begin
                lut_a_q <= lut_a;
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: directed scenarios plus constrained-random traffic against a
// behavioural arbitration model; results are checked by a queue-based scoreboard.
module tb_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] addr = 32'h0;
    logic [3:0]  gnt;
    logic [7:0]  lut_a;
    logic [7:0]  lut_qspo = 8'h00;
    logic [3:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Scoreboard entry: {issue cycle[15:0], requester[1:0], data[7:0]}
    logic [25:0] exp_q[$];

    // Reference model state
    int         m_ptr  = 0;
    logic [7:0] m_last = 8'h00;

    lut_arbiter #(.AW(8), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .lut_a    (lut_a),
        .lut_qspo (lut_qspo),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        lut_qspo <= lut_a ^ 8'hA5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One bus cycle: drive after the edge, compare combinational outputs on the falling edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [31:0] ad);
        int         win;
        int         base;
        logic [3:0] e_gnt;
        logic [7:0] e_a;
        @(posedge clk);
        #1;
        rst  = r;
        req  = rq;
        addr = ad;
        @(negedge clk);
`ifdef LUT_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        win = -1;
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && rq[(base + k) % 4]) win = (base + k) % 4;
            end
        end
        e_gnt = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        if (r) e_a = 8'h00;
        else if (win >= 0) e_a = ad[win*8 +: 8];
        else e_a = m_last;
        check("gnt", {28'h0, gnt}, {28'h0, e_gnt});
        check("busy", {31'h0, busy}, {31'h0, (win >= 0)});
        check("lut_a", {24'h0, lut_a}, {24'h0, e_a});
        if (r) begin
            m_ptr  = 0;
            m_last = 8'h00;
        end else if (win >= 0) begin
            m_ptr  = (win + 1) % 4;
            m_last = e_a;
            exp_q.push_back({cyc[15:0], 2'(win), e_a ^ 8'hA5});
        end
    endtask

    // Monitor: rd_valid must pulse exactly one cycle after each recorded grant.
    always @(negedge clk) begin
        logic [25:0] f;
        logic [3:0]  e_rv;
        e_rv = 4'b0000;
        f    = '0;
        if (exp_q.size() > 0) begin
            f = exp_q[0];
            if (int'(f[25:10]) == cyc - 1) e_rv = 4'b0001 << f[9:8];
        end
        if (rd_valid !== 4'b0000 || e_rv !== 4'b0000)
            check("rd_valid", {28'h0, rd_valid}, {28'h0, e_rv});
        if (e_rv !== 4'b0000) begin
            check("rd_data", {24'h0, rd_data}, {24'h0, f[7:0]});
            void'(exp_q.pop_front());
        end
    end

    logic [3:0]  pend;
    logic [31:0] paddr;
    int          win_seen;

    initial begin
        // Reset state
        drive(1'b1, 4'b0000, 32'h0);
        drive(1'b1, 4'b1111, 32'h44332211);
        // Single lookup from requester 1 at 0x33 -> data 0x96
        drive(1'b0, 4'b0010, 32'h0000_3300);
        drive(1'b0, 4'b0000, 32'h0);
        // All four requesting for 8 cycles
        drive(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, 32'hD4C3B2A1);
        // Wrap from requester 3 to requester 0
        drive(1'b1, 4'b0000, 32'h0);
        drive(1'b0, 4'b0100, 32'h0077_0000);
        drive(1'b0, 4'b1001, 32'h9900_0088);
        drive(1'b0, 4'b1001, 32'h9900_0088);
        // Reset arriving while requester 2 would win
        drive(1'b0, 4'b0010, 32'h0000_5500);
        drive(1'b1, 4'b0100, 32'h0066_0000);
        drive(1'b0, 4'b0000, 32'h0);
        drive(1'b0, 4'b1111, 32'h0102_0304);
        // Idle after a grant at 0x10: address must park
        drive(1'b0, 4'b1000, 32'h1000_0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 32'hFFFF_FFFF);

        // Random traffic: pending requesters hold req/addr until granted
        pend  = 4'b0000;
        paddr = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic r;
            int   b;
            r = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]           = 1'b1;
                    paddr[i*8 +: 8]   = 8'($urandom);
                end
            end
`ifdef LUT_ARB_FIXED_PRIO_EN
            b = 0;
`else
            b = m_ptr;
`endif
            win_seen = -1;
            if (!r) begin
                for (int k = 0; k < 4; k++)
                    if (win_seen < 0 && pend[(b + k) % 4]) win_seen = (b + k) % 4;
            end
            drive(r, pend, paddr);
            if (win_seen >= 0) pend[win_seen] = 1'b0;
        end

        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 32'h0);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
